// File: rtl/heap_sort_drain_if.sv
// Element-stream bundle between the heap sorter, the drain stage and the downstream consumer.
// The slave modport is the drain's view, and the master modport is the environment's view.
interface heap_sort_drain_if #(
  parameter int ELEM_W = 23,
  parameter int N_ELEM = 7,
  parameter int IDX_W  = 3
);
  localparam int VEC_W = ELEM_W * N_ELEM;

  logic [VEC_W-1:0]  vec_i;
  logic              vec_valid_i;
  logic              vec_ready_o;
  logic [ELEM_W-1:0] elem_o;
  logic              elem_valid_o;
  logic              elem_ready_i;
  logic              elem_last_o;
  logic [IDX_W-1:0]  elem_idx_o;
  logic              busy_o;
  logic              order_err_o;

  modport slave (
    input  vec_i, vec_valid_i, elem_ready_i,
    output vec_ready_o, elem_o, elem_valid_o, elem_last_o, elem_idx_o, busy_o, order_err_o
  );

  modport master (
    output vec_i, vec_valid_i, elem_ready_i,
    input  vec_ready_o, elem_o, elem_valid_o, elem_last_o, elem_idx_o, busy_o, order_err_o
  );
endinterface

// File: rtl/heap_sort_drain.sv
// Replays one sorted parallel vector as a serial valid/ready element stream. Back-to-back vectors run with no bubble.
// Defining HEAP_SORT_DRAIN_ORDER_CHECK_EN enables a sticky ascending-order checker on the stream.
module heap_sort_drain #(
  parameter int ELEM_W = 23,
  parameter int N_ELEM = 7,
  parameter int IDX_W  = 3
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  heap_sort_drain_if.slave  bus
);
  localparam int             VEC_W    = ELEM_W * N_ELEM;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   sreg_q, sreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               in_stream;
  logic               beat_acc;
  logic               last_beat;
  logic               vec_ready;
  logic               capture;
  logic [ELEM_W-1:0]  elem;

  assign elem = sreg_q[VEC_W-1 -: ELEM_W];

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    idx_d     = idx_q;
    in_stream = (state_q == STREAM);
    beat_acc  = in_stream && bus.elem_ready_i;
    last_beat = in_stream && (idx_q == LAST_IDX);
    // The last accepted beat frees the register in the same cycle. That path gives the zero-bubble handoff.
    vec_ready = !system1000_rst && (!in_stream || (beat_acc && last_beat));
    capture   = bus.vec_valid_i && vec_ready;

    if (capture) begin
      sreg_d  = bus.vec_i;
      idx_d   = '0;
      state_d = STREAM;
    end else if (beat_acc) begin
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        sreg_d = sreg_q << ELEM_W;
        idx_d  = idx_q + IDX_W'(1);
      end
    end
  end

  // NOTE: state updates use non-blocking assignments, so every flop samples the pre-edge values.
  // NOTE: the shift register is reset too, so elem_o reads zero out of reset rather than stale data.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.vec_ready_o  = vec_ready;
  assign bus.elem_o       = elem;
  assign bus.elem_valid_o = in_stream;
  assign bus.elem_last_o  = last_beat;
  assign bus.elem_idx_o   = idx_q;
  assign bus.busy_o       = in_stream;

`ifdef HEAP_SORT_DRAIN_ORDER_CHECK_EN
  logic [ELEM_W-1:0] prev_q;
  logic              err_q;

  // Comparisons start fresh at index 0, so the checker never compares elements from different vectors.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else if (beat_acc) begin
      prev_q <= elem;
      if ((idx_q != '0) && (elem < prev_q)) err_q <= 1'b1;
    end
  end

  assign bus.order_err_o = err_q;
`else
  assign bus.order_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_heap_sort_drain.sv
// Directed bench for heap_sort_drain: reset, free-running stream, backpressure, back-to-back vectors, mid-stream reset and order check.
module tb_heap_sort_drain;
  localparam int ELEM_W = 23;
  localparam int N_ELEM = 7;
  localparam int IDX_W  = 3;
  localparam int VEC_W  = ELEM_W * N_ELEM;
`ifdef HEAP_SORT_DRAIN_ORDER_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   exp_e [N_ELEM];
  bit   err_exp;
  logic [VEC_W-1:0] v1, v2;

  heap_sort_drain_if #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .IDX_W(IDX_W)) bus ();

  heap_sort_drain #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .IDX_W(IDX_W)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp_seq(input int base);
    for (int k = 0; k < N_ELEM; k++) exp_e[k] = base + k;
  endtask

  function automatic logic [VEC_W-1:0] pack_exp();
    logic [VEC_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_ELEM; k++) v[VEC_W-1-k*ELEM_W -: ELEM_W] = ELEM_W'(exp_e[k]);
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(bus.elem_valid_o), 64'd0);
    check({tag, "_busy"},  64'(bus.busy_o),       64'd0);
    check({tag, "_last"},  64'(bus.elem_last_o),  64'd0);
    check({tag, "_vrdy"},  64'(bus.vec_ready_o),  64'd1);
    check({tag, "_err"},   64'(bus.order_err_o),  64'(err_exp));
  endtask

  // Streams the vector in exp_e. It stalls for 3 cycles before the beats at indices stall_a and stall_b.
  task automatic stream_check(input string tag, input int stall_a, input int stall_b);
    for (int k = 0; k < N_ELEM; k++) begin
      if (k == stall_a || k == stall_b) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          bus.elem_ready_i = 1'b0;
          #1;
          check({tag, "_stall_valid"}, 64'(bus.elem_valid_o), 64'd1);
          check({tag, "_stall_elem"},  64'(bus.elem_o),       64'(exp_e[k]));
          check({tag, "_stall_idx"},   64'(bus.elem_idx_o),   64'(k));
          check({tag, "_stall_vrdy"},  64'(bus.vec_ready_o),  64'd0);
        end
      end
      @(negedge clk);
      bus.elem_ready_i = 1'b1;
      #1;
      check({tag, "_valid"}, 64'(bus.elem_valid_o), 64'd1);
      check({tag, "_busy"},  64'(bus.busy_o),       64'd1);
      check({tag, "_elem"},  64'(bus.elem_o),       64'(exp_e[k]));
      check({tag, "_idx"},   64'(bus.elem_idx_o),   64'(k));
      check({tag, "_last"},  64'(bus.elem_last_o),  64'(k == N_ELEM - 1));
      check({tag, "_vrdy"},  64'(bus.vec_ready_o),  64'(k == N_ELEM - 1));
      check({tag, "_err"},   64'(bus.order_err_o),  64'(err_exp));
      if (CHK_EN && k > 0 && exp_e[k] < exp_e[k-1]) err_exp = 1'b1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    err_exp = 1'b0;
    rst = 1'b1;
    bus.vec_i        = '0;
    bus.vec_valid_i  = 1'b0;
    bus.elem_ready_i = 1'b0;

    // Reset, then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.elem_valid_o), 64'd0);
    check("rst_vrdy",  64'(bus.vec_ready_o),  64'd0);
    check("rst_busy",  64'(bus.busy_o),       64'd0);
    check("rst_elem",  64'(bus.elem_o),       64'd0);
    check("rst_idx",   64'(bus.elem_idx_o),   64'd0);
    check("rst_last",  64'(bus.elem_last_o),  64'd0);
    check("rst_err",   64'(bus.order_err_o),  64'd0);
    rst = 1'b0;
    #1;
    check_idle("post_rst");
    check("post_rst_elem", 64'(bus.elem_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_idle("idle_hold");

    // Single vector 1..7 with the consumer always ready
    set_exp_seq(1);
    @(negedge clk);
    bus.vec_i = pack_exp();
    bus.vec_valid_i = 1'b1;
    bus.elem_ready_i = 1'b1;
    #1;
    check("single_cap_vrdy", 64'(bus.vec_ready_o), 64'd1);
    check("single_cap_valid", 64'(bus.elem_valid_o), 64'd0);
    @(posedge clk);
    #1;
    bus.vec_valid_i = 1'b0;
    stream_check("single", -1, -1);
    @(negedge clk);
    #1;
    check_idle("single_end");

    // Backpressure before the beats at indices 2 and 5
    @(negedge clk);
    bus.vec_i = pack_exp();
    bus.vec_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.vec_valid_i = 1'b0;
    stream_check("bp", 2, 5);
    @(negedge clk);
    #1;
    check_idle("bp_end");

    // Back-to-back 1..7 then 10..16, with vec_valid_i held high through the first vector
    set_exp_seq(10);
    v2 = pack_exp();
    set_exp_seq(1);
    v1 = pack_exp();
    @(negedge clk);
    bus.vec_i = v1;
    bus.vec_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.vec_i = v2;
    stream_check("b2b_a", -1, -1);
    @(posedge clk);
    #1;
    bus.vec_valid_i = 1'b0;
    set_exp_seq(10);
    stream_check("b2b_b", -1, -1);
    @(negedge clk);
    #1;
    check_idle("b2b_end");

    // Reset after the beat carrying 3 has been accepted
    set_exp_seq(1);
    @(negedge clk);
    bus.vec_i = pack_exp();
    bus.vec_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.vec_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_pre_elem", 64'(bus.elem_o),     64'd4);
    check("mid_pre_idx",  64'(bus.elem_idx_o), 64'd3);
    rst = 1'b1;
    err_exp = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.elem_valid_o), 64'd0);
    check("mid_rst_busy",  64'(bus.busy_o),       64'd0);
    check("mid_rst_idx",   64'(bus.elem_idx_o),   64'd0);
    check("mid_rst_elem",  64'(bus.elem_o),       64'd0);
    check("mid_rst_vrdy",  64'(bus.vec_ready_o),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_exp_seq(20);
    bus.vec_i = pack_exp();
    bus.vec_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.vec_valid_i = 1'b0;
    stream_check("after_rst", -1, -1);
    @(negedge clk);
    #1;
    check_idle("after_rst_end");

    // Out-of-order vector 1,2,9,4,5,6,7
    exp_e = '{1, 2, 9, 4, 5, 6, 7};
    @(negedge clk);
    bus.vec_i = pack_exp();
    bus.vec_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.vec_valid_i = 1'b0;
    stream_check("order", -1, -1);
    repeat (3) @(posedge clk);
    #1;
    check_idle("order_end");
    check("order_sticky", 64'(bus.order_err_o), 64'(CHK_EN));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
